// File: rtl/window_sum_stage_pkg.sv
// Shared configuration for the window-sum stage: default geometry and derived widths.
package window_sum_stage_pkg;

    localparam int unsigned K_DEF           = 3;
    localparam int unsigned PIXEL_WIDTH_DEF = 8;
    localparam int unsigned IMG_WIDTH_DEF   = 8;
    localparam int unsigned IMG_HEIGHT_DEF  = 5;
    localparam int unsigned SUM_WIDTH_DEF   = PIXEL_WIDTH_DEF + $clog2(K_DEF * K_DEF);

    // Reciprocal constant for floor(sum / (k*k)); exact for every sum below 2**sum_w.
    function automatic int unsigned mean_shift(input int unsigned sum_w, input int unsigned k);
        return sum_w + $clog2(k * k);
    endfunction

    function automatic longint unsigned mean_recip(input int unsigned sum_w, input int unsigned k);
        longint unsigned one;
        one = 64'd1 << mean_shift(sum_w, k);
        return (one + longint'(k * k) - 1) / longint'(k * k);
    endfunction

endpackage

// File: rtl/column_adder.sv
// Combinational unsigned adder of N packed terms, each zero-extended to SUM_WIDTH.
module column_adder
    import window_sum_stage_pkg::*;
#(
    parameter int unsigned N         = K_DEF,
    parameter int unsigned IN_WIDTH  = PIXEL_WIDTH_DEF,
    parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF
) (
    input  logic [N*IN_WIDTH-1:0] terms,
    output logic [SUM_WIDTH-1:0]  sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = sum + SUM_WIDTH'(terms[i*IN_WIDTH +: IN_WIDTH]);
        end
    end

endmodule

// File: rtl/window_sum_stage.sv
// Assembles KxK windows from incoming pixel columns and emits pipelined window sums.
// Optional WINDOW_MEAN_EN adds out_mean = floor(out_sum / (K*K)).
module window_sum_stage
    import window_sum_stage_pkg::*;
#(
    parameter int unsigned K           = K_DEF,
    parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int unsigned SUM_WIDTH   = PIXEL_WIDTH + $clog2(K * K)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [K*PIXEL_WIDTH-1:0]      in_col,
    output logic                          out_valid,
    output logic [SUM_WIDTH-1:0]          out_sum,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
`ifdef WINDOW_MEAN_EN
    output logic [PIXEL_WIDTH-1:0]        out_mean,
`endif
    output logic                          frame_done
);

    localparam int unsigned OUT_ROWS = IMG_HEIGHT - K + 1;
    localparam int unsigned XW       = $clog2(IMG_WIDTH);
    localparam int unsigned YW       = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] COL_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [XW-1:0] COL_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(OUT_ROWS - 1);

    logic [XW-1:0]          col_cnt;
    logic [YW-1:0]          row_cnt;
    logic [K*SUM_WIDTH-1:0] csum;
    logic [K*PIXEL_WIDTH-1:0] col_gated;
    logic [SUM_WIDTH-1:0]   col_sum;
    logic [SUM_WIDTH-1:0]   win_sum;
    logic                   s1_valid;
    logic                   s1_last;
    logic [XW-1:0]          s1_x;
    logic [YW-1:0]          s1_y;

    // A floating bus while in_valid is low must never reach the adder.
    assign col_gated = in_valid ? in_col : '0;

    column_adder #(
        .N         (K),
        .IN_WIDTH  (PIXEL_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_col_add (
        .terms (col_gated),
        .sum   (col_sum)
    );

    column_adder #(
        .N         (K),
        .IN_WIDTH  (SUM_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_win_add (
        .terms (csum),
        .sum   (win_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            csum     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (in_valid) begin
            csum     <= {csum[(K-1)*SUM_WIDTH-1:0], col_sum};
            s1_valid <= (col_cnt >= COL_FIRST);
            s1_last  <= (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
            s1_x     <= col_cnt - COL_FIRST;
            s1_y     <= row_cnt;
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end else begin
            s1_valid <= 1'b0;
        end
    end

`ifdef WINDOW_MEAN_EN
    localparam int unsigned     MSH   = mean_shift(SUM_WIDTH, K);
    localparam int unsigned     PRODW = SUM_WIDTH + MSH + 1;
    localparam logic [PRODW-1:0] RECIP = PRODW'(mean_recip(SUM_WIDTH, K));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_sum    <= '0;
            out_x      <= '0;
            out_y      <= '0;
`ifdef WINDOW_MEAN_EN
            out_mean   <= '0;
`endif
        end else begin
            out_valid  <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                out_sum <= win_sum;
                out_x   <= s1_x;
                out_y   <= s1_y;
`ifdef WINDOW_MEAN_EN
                out_mean <= PIXEL_WIDTH'((PRODW'(win_sum) * RECIP) >> MSH);
`endif
            end
        end
    end

endmodule

// File: tb/tb_window_sum_stage.sv
// Scoreboard bench for window_sum_stage: image-level reference model, decoupled monitor.
module tb_window_sum_stage;
    import window_sum_stage_pkg::*;

    localparam int K        = K_DEF;
    localparam int PW       = PIXEL_WIDTH_DEF;
    localparam int W        = IMG_WIDTH_DEF;
    localparam int H        = IMG_HEIGHT_DEF;
    localparam int SW       = SUM_WIDTH_DEF;
    localparam int CW       = K * PW;
    localparam int OUT_ROWS = H - K + 1;
    localparam int XW       = $clog2(W);
    localparam int YW       = $clog2(H);
    localparam int WIN_PER_FRAME = (W - K + 1) * OUT_ROWS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [CW-1:0] in_col;
    logic          out_valid;
    logic [SW-1:0] out_sum;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          frame_done;
`ifdef WINDOW_MEAN_EN
    logic [PW-1:0] out_mean;
`endif

    window_sum_stage #(
        .K           (K),
        .PIXEL_WIDTH (PW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .SUM_WIDTH   (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_col     (in_col),
        .out_valid  (out_valid),
        .out_sum    (out_sum),
        .out_x      (out_x),
        .out_y      (out_y),
`ifdef WINDOW_MEAN_EN
        .out_mean   (out_mean),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          sum;
        int          x;
        int          y;
        bit          last;
        int unsigned cyc;
    } exp_t;

    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            fd_seen = 0;
    int            fd_exp = 0;
    int            win_seen = 0;
    int            n_push = 0;
    logic [CW-1:0] img [OUT_ROWS][W];
    int            mcol = 0;
    int            mrow = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pix_total(input logic [CW-1:0] c);
        int s = 0;
        for (int p = 0; p < K; p++) s += int'(c[p*PW +: PW]);
        return s;
    endfunction

    // Window (x,y) is the sum of every pixel in columns x..x+K-1 of column-row y.
    task automatic model_accept(input logic [CW-1:0] c, input int unsigned acc_edge);
        img[mrow][mcol] = c;
        if (mcol >= K - 1) begin
            exp_t e;
            e.sum = 0;
            for (int x = mcol - K + 1; x <= mcol; x++) e.sum += pix_total(img[mrow][x]);
            e.x    = mcol - K + 1;
            e.y    = mrow;
            e.last = (mcol == W - 1) && (mrow == OUT_ROWS - 1);
            e.cyc  = acc_edge + 1;
            sbq.push_back(e);
            n_push++;
            if (e.last) fd_exp++;
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == OUT_ROWS - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic drive(input bit v, input logic [CW-1:0] c);
        @(negedge clk);
        in_valid = v;
        in_col   = v ? c : {CW{1'bx}};
        if (v) model_accept(c, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0);
    endtask

    function automatic logic [CW-1:0] flat_col(input int v);
        logic [CW-1:0] c;
        for (int p = 0; p < K; p++) c[p*PW +: PW] = PW'(v);
        return c;
    endfunction

    function automatic logic [CW-1:0] rand_col();
        logic [CW-1:0] c;
        for (int p = 0; p < K; p++) c[p*PW +: PW] = PW'($urandom);
        return c;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_col   = rand_col();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum", out_sum, 0);
            check("rst_out_x", out_x, 0);
            check("rst_out_y", out_y, 0);
            check("rst_frame_done", frame_done, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        mcol = 0;
        mrow = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_window: no out_valid for x=%0d y=%0d, expected at edge %0d",
                         sbq[0].x, sbq[0].y, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            if (out_valid) begin
                win_seen++;
                if (frame_done) fd_seen++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_window: out_valid with sum=%0d x=%0d y=%0d, expected none",
                             out_sum, out_x, out_y);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("latency_edge", cyc, e.cyc);
                    check("out_sum", out_sum, e.sum);
                    check("out_x", out_x, e.x);
                    check("out_y", out_y, e.y);
                    check("frame_done", frame_done, e.last);
`ifdef WINDOW_MEAN_EN
                    check("out_mean", out_mean, e.sum / (K * K));
`endif
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
        end
    end

    initial begin
        int w0;
        int f0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_col   = '0;
        do_reset(3);

        // Constant all-255 frame, continuous.
        w0 = win_seen; f0 = fd_seen;
        for (int i = 0; i < W * OUT_ROWS; i++) drive(1'b1, flat_col((1 << PW) - 1));
        idle(4);
        check("const_windows", win_seen - w0, WIN_PER_FRAME);
        check("const_frame_done", fd_seen - f0, 1);

        // Ramp: pixel value equals column index.
        for (int i = 0; i < W * OUT_ROWS; i++) drive(1'b1, flat_col(i % W));
        idle(4);

        // Ramp with a bubble after every column.
        w0 = win_seen;
        for (int i = 0; i < W * OUT_ROWS; i++) begin
            drive(1'b1, flat_col(i % W));
            drive(1'b0, '0);
        end
        idle(4);
        check("bubble_windows", win_seen - w0, WIN_PER_FRAME);

        // Reset mid-frame, then a clean all-255 frame.
        for (int i = 0; i < 10; i++) drive(1'b1, rand_col());
        idle(3);
        do_reset(2);
        w0 = win_seen; f0 = fd_seen;
        for (int i = 0; i < W * OUT_ROWS; i++) drive(1'b1, flat_col((1 << PW) - 1));
        idle(4);
        check("post_rst_windows", win_seen - w0, WIN_PER_FRAME);
        check("post_rst_frame_done", fd_seen - f0, 1);

        // Two back-to-back all-1 frames.
        f0 = fd_seen;
        for (int i = 0; i < 2 * W * OUT_ROWS; i++) drive(1'b1, flat_col(1));
        idle(4);
        check("b2b_frame_done", fd_seen - f0, 2);

        // Random pixels with random gaps over at least 1000 windows.
        w0 = n_push;
        while (n_push - w0 < 1000) begin
            drive(1'b1, rand_col());
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(5);

        check("queue_empty", sbq.size(), 0);
        check("frame_done_total", fd_seen, fd_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
